// File: rtl/hps_cmd_decoder_pkg.sv
// Shared field positions, opcode constants and the queued command type
// for the HPS command decoder.
package hps_cmd_pkg;

   localparam int TOG_BIT  = 31;
   localparam int OPC_MSB  = 30;
   localparam int OPC_LSB  = 24;
   localparam int ADDR_MSB = 23;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   localparam logic [6:0] OPC_NOP = 7'h00;
   localparam logic [6:0] OPC_CLR = 7'h7F;

   localparam int ST_ACK_BIT  = 31;
   localparam int ST_OVF_BIT  = 30;
   localparam int ST_DROP_MSB = 23;
   localparam int ST_DROP_LSB = 16;
   localparam int ST_FILL_MSB = 15;
   localparam int ST_FILL_LSB = 8;
   localparam int ST_LAST_MSB = 6;
   localparam int ST_LAST_LSB = 0;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [7:0]  addr;
      logic [15:0] data;
   } cmd_t;

   function automatic cmd_t decode_cmd(input logic [OPC_MSB:0] w);
      cmd_t c;
      c.opcode = w[OPC_MSB:OPC_LSB];
      c.addr   = w[ADDR_MSB:ADDR_LSB];
      c.data   = w[DATA_MSB:DATA_LSB];
      return c;
   endfunction

endpackage

// File: rtl/hps_cmd_decoder_fifo.sv
// First-word-fall-through command FIFO: register array, wrapping pointers,
// occupancy counter one bit wider than the pointers.
module hps_cmd_fifo
   import hps_cmd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  cmd_t                     wdata,
   input  logic                     pop,
   output cmd_t                     rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry 0 is cleared so the head outputs read zero straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_comb begin
      rdata = mem_q[rd_ptr_q];
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
      count = count_q;
   end

endmodule

// File: rtl/hps_cmd_decoder.sv
// Turns toggle-flagged HPS command words into queued valid/ready commands
// and reports acknowledge, overflow and drop statistics back to the HPS.
module hps_cmd_decoder
   import hps_cmd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cmd_word,
   output logic        cmd_valid,
   output logic [6:0]  cmd_opcode,
   output logic [7:0]  cmd_addr,
   output logic [15:0] cmd_data,
   input  logic        cmd_ready,
   output logic [31:0] status_word
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             prev_tog_q, prev_tog_d;
   logic             ack_q, ack_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic [6:0]       last_opc_q, last_opc_d;

   logic             new_cmd, is_nop, is_clr, want_push;
   logic             push, pop, drop;
   logic             full, empty;
   logic [CNT_W-1:0] count;
   logic [7:0]       fill_ext;
   cmd_t             cmd_in, head;

   always_comb begin
      new_cmd   = cmd_word[TOG_BIT] ^ prev_tog_q;
      cmd_in    = decode_cmd(cmd_word[OPC_MSB:0]);
      is_nop    = (cmd_in.opcode == OPC_NOP);
      is_clr    = (cmd_in.opcode == OPC_CLR);
      want_push = new_cmd && !is_nop && !is_clr;
      pop       = !empty && cmd_ready;
      // A full FIFO still accepts when the head leaves in the same cycle.
      push      = want_push && (!full || pop);
      drop      = want_push && full && !pop;
   end

   always_comb begin
      prev_tog_d = cmd_word[TOG_BIT];
      ack_d      = new_cmd ? cmd_word[TOG_BIT] : ack_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      last_opc_d = push ? cmd_in.opcode : last_opc_q;
      if (new_cmd && is_clr) begin
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // prev_tog tracks the input even in reset so release never looks like a toggle.
   always_ff @(posedge clk) begin
      prev_tog_q <= prev_tog_d;
      if (reset) begin
         ack_q      <= cmd_word[TOG_BIT];
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
         last_opc_q <= '0;
      end else begin
         ack_q      <= ack_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
         last_opc_q <= last_opc_d;
      end
   end

   hps_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (cmd_in),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      fill_ext              = '0;
      fill_ext[CNT_W-1:0]   = count;
      status_word           = '0;
      status_word[ST_ACK_BIT]                = ack_q;
      status_word[ST_OVF_BIT]                = ovf_q;
      status_word[ST_DROP_MSB:ST_DROP_LSB]   = drop_cnt_q;
      status_word[ST_FILL_MSB:ST_FILL_LSB]   = fill_ext;
      status_word[ST_LAST_MSB:ST_LAST_LSB]   = last_opc_q;
      cmd_valid  = !empty;
      cmd_opcode = head.opcode;
      cmd_addr   = head.addr;
      cmd_data   = head.data;
   end

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Directed bench for hps_cmd_decoder: stimulus queues expected commands,
// a negedge monitor checks every handshake against that queue.
module tb_hps_cmd_decoder;
   import hps_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cmd_word;
   logic        cmd_valid;
   logic [6:0]  cmd_opcode;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        cmd_ready;
   logic [31:0] status_word;

   int   checks   = 0;
   int   failures = 0;
   cmd_t exp_q[$];
   logic tog;

   always #5 clk = ~clk;

   hps_cmd_decoder #(.DEPTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_word    (cmd_word),
      .cmd_valid   (cmd_valid),
      .cmd_opcode  (cmd_opcode),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .status_word (status_word)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [6:0] opc, input logic [7:0] addr,
                       input logic [15:0] data, input bit queued);
      cmd_t c;
      tog      = ~tog;
      cmd_word = {tog, opc, addr, data};
      if (queued) begin
         c.opcode = opc;
         c.addr   = addr;
         c.data   = data;
         exp_q.push_back(c);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      cmd_t a, e;
      if (!reset && cmd_valid && cmd_ready) begin
         a = {cmd_opcode, cmd_addr, cmd_data};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop: got %h expected none", a);
         end else begin
            e = exp_q.pop_front();
            chk("pop_payload", {1'b0, a}, {1'b0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      cmd_ready = 1'b0;
      cmd_word  = 32'h8000_0000;
      tog       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", cmd_valid, 1'b0);
      chk("rst_status", status_word, 32'h8000_0000);
      chk("rst_head", {cmd_opcode, cmd_addr, cmd_data}, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_no_spurious", cmd_valid, 1'b0);

      send(7'h00, 8'h00, 16'h0000, 0);
      chk("nop_status", status_word, 32'h0000_0000);
      chk("nop_valid", cmd_valid, 1'b0);

      send(7'h03, 8'h12, 16'hABCD, 1);
      chk("first_valid", cmd_valid, 1'b1);
      chk("first_head", {1'b0, cmd_opcode, cmd_addr, cmd_data}, 32'h0312_ABCD);
      chk("first_status", status_word, 32'h8000_0103);
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("first_drained", status_word, 32'h8000_0003);
      chk("first_valid_low", cmd_valid, 1'b0);
      cmd_ready = 1'b0;

      for (int i = 0; i < 8; i++)
         send(7'h10 + 7'(i), 8'h20 + 8'(i), 16'h1000 + 16'(i * 16'h0111), 1);
      chk("full_status", status_word, 32'h8000_0817);
      chk("full_head", cmd_opcode, 7'h10);

      send(7'h55, 8'hAA, 16'h5555, 0);
      chk("drop_status", status_word, 32'h4001_0817);

      cmd_ready = 1'b1;
      send(7'h1A, 8'h2A, 16'h3A3A, 1);
      chk("full_push_pop_status", status_word, 32'hC001_081A);

      for (int k = 0; k < 20; k++) begin
         if (!cmd_valid) break;
         @(posedge clk);
         #1;
      end
      chk("drain_done", cmd_valid, 1'b0);
      chk("drain_queue_left", exp_q.size(), 0);
      chk("drain_status", status_word, 32'hC001_001A);
      cmd_ready = 1'b0;

      send(7'h7F, 8'h00, 16'h0000, 0);
      chk("clr_status", status_word, 32'h0000_001A);
      chk("clr_valid", cmd_valid, 1'b0);

      for (int i = 0; i < 8; i++)
         send(7'h30 + 7'(i), 8'h40 + 8'(i), 16'hC000 + 16'(i), 1);
      chk("refill_status", status_word, 32'h0000_0837);
      for (int i = 0; i < 300; i++) begin
         send(7'h66, 8'(i), 16'hBEEF, 0);
         if (i == 253) chk("drop_cnt_254", status_word[23:16], 8'hFE);
         if (i == 254) chk("drop_cnt_255", status_word[23:16], 8'hFF);
      end
      chk("drop_saturated", status_word, 32'h40FF_0837);

      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_full_valid", cmd_valid, 1'b0);
      chk("rst_full_fill", status_word[15:8], 8'h00);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_full_status", status_word, 32'h0000_0000);

      for (int i = 0; i < 5; i++)
         send(7'h40 + 7'(i), 8'(i), 16'h7000 + 16'(i), 1);
      chk("five_status", status_word, 32'h8000_0544);
      chk("five_valid", cmd_valid, 1'b1);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_five_valid", cmd_valid, 1'b0);
      chk("rst_five_fill", status_word[15:8], 8'h00);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_five_status", status_word, 32'h8000_0000);
      chk("rst_five_valid_after", cmd_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hps_cmd_decoder.md
Name: hps_cmd_decoder

Overview:
- Consumes the 32-bit level word driven by the HPS-facing output PIO and turns it into discrete, buffered commands for the panel fabric logic.
- HPS signals a new command by toggling bit 31. The block detects the toggle, decodes the word, and queues it in a small FIFO.
- Queued commands are presented downstream on a valid/ready interface.
- A 32-bit status word is returned for the HPS-facing input PIO. It carries the acknowledge toggle and error counters.

Parameters:
- DEPTH, 8, FIFO entries; power of 2; legal range 2..128.
- PTR_W, $clog2(DEPTH), derived pointer width; not overridable.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_word  in  32  HPS command word. Fields: [31] toggle, [30:24] opcode, [23:16] addr, [15:0] data.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_opcode  out  7  head opcode.
- cmd_addr  out  8  head address.
- cmd_data  out  16  head data.
- cmd_ready  in  1  downstream accepts head.
- status_word  out  32  to HPS input PIO. Fields:
  - [31] ack_toggle
  - [30] overflow
  - [29:24] zero
  - [23:16] drop_count
  - [15:8] fill level, zero-extended
  - [7] zero
  - [6:0] last accepted opcode

Behaviour:
- Edge detection:
  - prev_tog is a register; prev_tog <= cmd_word[31] every cycle, including during reset, so no spurious command appears at reset release.
  - new_cmd = cmd_word[31] ^ prev_tog (combinational, cycle N).
- Reset values:
  - FIFO empty; cmd_valid=0; cmd_opcode/addr/data=0 (head RAM entry 0 cleared).
  - ack_toggle = cmd_word[31] sampled at reset.
  - overflow=0, drop_count=0, last opcode=0.
- Opcode classes, all decided on new_cmd at cycle N:
  - 0x00 NOP: not queued.
  - 0x7F CLR_STATUS: not queued; overflow<=0 and drop_count<=0 at N+1.
  - Any other opcode: push {opcode, addr, data} if space is available.
- Space rule: push allowed when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - If no space: command dropped; overflow<=1 (sticky); drop_count saturating increment (stays at 255).
- Acknowledge: ack_toggle <= cmd_word[31] at N+1 for every detected toggle, whether queued, dropped, NOP or CLR. HPS therefore never stalls; it polls bit 31 equal to its own toggle, then checks overflow.
- Last opcode: status[6:0] updates at N+1 only on a successful push.
- FIFO:
  - First-word-fall-through, register array, read/write pointers PTR_W bits that wrap modulo DEPTH, count PTR_W+1 bits.
  - Pop on cmd_valid && cmd_ready.
  - Push to an empty FIFO at N gives cmd_valid=1 at N+1 (latency 1).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Head outputs hold stable while cmd_valid && !cmd_ready.
- Two toggles in consecutive cycles are each detected. HPS cannot produce this; no merging is performed.
- Reset mid-operation: queued commands are discarded. The downstream must treat cmd_valid falling without a handshake as a flush.
- Status registers and their sources:
  - status_word[31] and [30] come directly from registers.
  - [23:16] comes from the drop_count register.
  - [15:8] comes from the count register, zero-extended.
  - [6:0] comes from the last-opcode register.
  - All remaining bits are zero.

Decomposition:
- Package hps_cmd_pkg:
  - Field positions TOG_BIT=31, OPC_MSB/LSB=30/24, ADDR_MSB/LSB=23/16, DATA_MSB/LSB=15/0.
  - Constants OPC_NOP=7'h00, OPC_CLR=7'h7F.
  - Typedef cmd_t = struct {opcode[6:0], addr[7:0], data[15:0]} (31 bits).
  - Status field position constants.
- One sub-module, hps_cmd_fifo: parameterised FWFT FIFO with push/pop/full/empty/count.
- Top level holds edge detect, opcode classification, status registers and output mapping.

Test Plan:
- Reset release with cmd_word=32'h8000_0000 -> no cmd_valid; status[31]=1; status=32'h8000_0000.
- From toggle 0, cmd_word=32'h8312_ABCD -> cmd_valid at N+1 with opcode 0x03, addr 0x12, data 0xABCD; status[31]=1 at N+1; fill level=1; status[6:0]=0x03. With cmd_ready=1, fill level returns to 0 one cycle later.
- cmd_ready=0, 8 toggled commands (DEPTH=8) -> fill level=8, overflow=0. A 9th command -> dropped; overflow=1; drop_count=1; ack still toggles. Then drain with ready=1 -> 8 commands emerge in order with their exact payloads.
- FIFO full, cmd_ready=1 and a new toggle in the same cycle -> push accepted; count stays 8; drop_count unchanged.
- NOP toggle (opcode 0x00) -> ack toggles, nothing queued. CLR toggle (opcode 0x7F) after drops -> overflow=0 and drop_count=0 next cycle.
- 300 drops while full -> drop_count saturates at 8'hFF. Reset asserted with 5 queued -> cmd_valid=0 and fill level=0 the cycle after reset.
